// File: rtl/uart_tx_fifo.sv
// Byte-stream serialiser: valid/ready byte input, small synchronous FIFO,
// and an 8N1 UART transmitter clocked from clk_100.
`timescale 1ns/1ps

// state | meaning
// IDLE  | line high, waiting for a byte in the FIFO
// START | start bit (low) for one bit period
// DATA  | eight data bits, LSB first
// STOP  | stop bit (high); may chain straight into the next START
module uart_tx_fifo #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W     = 4
) (
  input  logic              clk_100,
  input  logic              rst,
  input  logic [7:0]        din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              tx,
  output logic              busy,
  output logic              overflow,
  output logic [ADDR_W:0]   fifo_count
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state;
  logic [7:0]        mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [CNT_W-1:0]  baud_cnt;
  logic [2:0]        bit_idx;
  logic [7:0]        shift;
  logic              push;
  logic              pop;
  logic              bit_end;
  logic              has_data;

  assign has_data  = (fifo_count != '0);
  assign bit_end   = (baud_cnt == BAUD_LAST);
  assign din_ready = (fifo_count != FULL);
  assign busy      = (state != IDLE) || has_data;
  assign push      = din_valid && din_ready;
  // A pop in STOP lets the next start bit follow with no idle gap.
  assign pop       = has_data && ((state == IDLE) || ((state == STOP) && bit_end));

  always_ff @(posedge clk_100) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk_100) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + (ADDR_W+1)'(1);
        2'b01:   fifo_count <= fifo_count - (ADDR_W+1)'(1);
        default: fifo_count <= fifo_count;
      endcase
      if (din_valid && !din_ready) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk_100) begin
    if (rst) begin
      state    <= IDLE;
      tx       <= 1'b1;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
    end else begin
      case (state)
        IDLE: begin
          tx       <= 1'b1;
          baud_cnt <= '0;
          if (pop) begin
            shift <= mem[rd_ptr];
            tx    <= 1'b0;
            state <= START;
          end
        end
        START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            tx       <= shift[0];
            shift    <= shift >> 1;
            bit_idx  <= '0;
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              tx      <= shift[0];
              shift   <= shift >> 1;
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (pop) begin
              shift <= mem[rd_ptr];
              tx    <= 1'b0;
              state <= START;
            end else begin
              tx    <= 1'b1;
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Byte-stream serialiser that sits downstream of the ov7675 capture block and drives ftdi_tx toward the host.
- Accepts 8-bit pixel/status bytes over a valid/ready handshake.
- Buffers them in a small synchronous FIFO.
- Transmits each byte as an 8N1 UART frame at a fixed baud rate derived from clk_100.

Parameters:
CLK_HZ, 100000000, frequency of clk_100 in Hz
BAUD, 115200, line rate; CLKS_PER_BIT = CLK_HZ/BAUD, integer truncation (868 at defaults); must be >= 2
FIFO_DEPTH, 16, byte entries; power of two, >= 2
ADDR_W, 4, log2(FIFO_DEPTH)

Ports:
clk_100  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
din  input  8  byte to transmit
din_valid  input  1  din is presented this cycle
din_ready  output  1  FIFO can accept a byte (= count != FIFO_DEPTH)
tx  output  1  UART serial out, idle high; connects to ftdi_tx
busy  output  1  high while state != IDLE or count != 0
overflow  output  1  sticky: a byte was offered while din_ready was low
fifo_count  output  ADDR_W+1  bytes currently held, 0..FIFO_DEPTH

Behaviour:
- Interface: one clock, clk_100; reset rst is synchronous and active-high.
- Reset values: tx=1, din_ready=1, busy=0, overflow=0, fifo_count=0, FSM=IDLE, FIFO pointers=0, baud counter=0, bit index=0.
- Reset mid-frame aborts the frame. tx is high from the cycle after the reset edge. FIFO contents are discarded.
- Write: accepted on an edge where din_valid && din_ready. The byte is stored at wr_ptr and wr_ptr increments, wrapping modulo FIFO_DEPTH.
- Full: din_ready is low when count == FIFO_DEPTH, even if a pop occurs in the same cycle. din_valid while full drops the byte and sets overflow. overflow is cleared only by rst.
- Simultaneous push and pop leaves count unchanged. Pop on empty never occurs.
- Registered outputs: tx, overflow, fifo_count. din_ready and busy are combinational from registered state.
- FSM states:
  - IDLE: tx=1. If count != 0: pop head into shift register, tx<=0, go START.
  - START: tx=0 for CLKS_PER_BIT cycles, then tx<=shift[0], go DATA.
  - DATA: each bit held CLKS_PER_BIT cycles, LSB first, 8 bits. After bit 7, tx<=1, go STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. At its last cycle, if count != 0, pop and go START directly (tx<=0, no idle gap); else go IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1, restarts on every state/bit change. Frame length is exactly 10*CLKS_PER_BIT cycles.
- Latency, idle and empty: write accepted at edge N; IDLE sees count=1 and pops at edge N+1; tx is low from N+1 onward.
- Back-to-back frames: start-bit falling edges are exactly 10*CLKS_PER_BIT cycles apart.
- din is don't-care when din_valid=0. Writes are accepted in every FSM state.

Test Plan:
(All use CLK_HZ=1000, BAUD=100, i.e. CLKS_PER_BIT=10, FIFO_DEPTH=16.)
1. Single byte: rst, then write 0x55 at edge N.
   -> tx low from N+1 for 10 cycles, then bits 1,0,1,0,1,0,1,0 at 10 cycles each, then stop high 10 cycles.
   -> busy falls at N+101; fifo_count returns 0 at N+1.
2. Back-to-back frames: write 0xA3 then 0x0F on consecutive cycles.
   -> Second start bit falls exactly 100 cycles after the first, with no idle gap.
   -> Decoded stream is 0xA3, 0x0F.
3. Overflow: write 0x00..0x11 (18 bytes) on consecutive edges 0..17.
   -> fifo_count reaches 16 after edge 16; din_ready low at edge 17; 0x11 dropped; overflow=1 and stays 1.
   -> Host decodes 0x00..0x10 in order.
4. Extremes: send 0x00 then 0xFF.
   -> 0x00 gives tx low for 90 cycles then high 10.
   -> 0xFF gives tx low 10 cycles then high 90 (stop merges into idle).
5. Reset mid-frame: assert rst for 1 cycle during bit 3 of 0xC6, with 3 bytes queued.
   -> tx=1 next cycle; fifo_count=0; overflow=0; busy=0.
   -> Subsequent write of 0x7E is framed correctly.
6. Pointer wrap: stream 40 bytes at 1 byte per 100 cycles.
   -> All 40 received intact and in order; overflow stays 0; fifo_count never exceeds 1.
